alu_share_arb: RTL
==================

Name: alu_share_arb

Overview:
- Time-shares one 32-bit combinational ALU (A, B, 3-bit ALU_OP in; F, ZF, OF out) between two requesters.
- Round-robin arbitration; operands and op are registered into the ALU.
- ALU result and flags are captured and returned with a requester ID over a valid/ready response channel.
- Sits between the sequencing logic of two datapath clients and the single shared ALU instance.

Parameters:
- W, 32, operand/result width; must match the ALU width.
- OPW, 3, op code width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_op  in  OPW  op: 000 and, 001 or, 010 xor, 011 nor, 100 add, 101 sub, 110 unsigned A<B, 111 B<<A.
- req0_a, req0_b  in  W  operands.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as above, requester 1.
- alu_a, alu_b  out  W  registered operands to the ALU.
- alu_op  out  OPW  registered op to the ALU.
- alu_f  in  W  ALU result.
- alu_zf, alu_of  in  1  ALU zero and overflow flags.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that owns the response.
- rsp_f  out  W  captured result.
- rsp_zf, rsp_of  out  1  captured flags.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: state IDLE; last_grant=1, so requester 0 wins first. All outputs 0: req*_ready, rsp_valid, rsp_id, rsp_f, rsp_zf, rsp_of, alu_a, alu_b, alu_op, busy.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational: high only for the granted requester, and only while in IDLE.
  - Grant rule: if exactly one valid, grant it. If both valid, grant the one that is not last_grant.
  - On a grant: latch op/a/b into alu_op/alu_a/alu_b, latch the ID, update last_grant, go to EXEC.
  - No valid: stay in IDLE; ALU input registers hold their old values.
- EXEC (one cycle): ALU settles from the registered inputs. At the cycle end, capture alu_f/alu_zf/alu_of into the rsp_* registers, set rsp_valid=1, go to RESP.
- RESP:
  - Hold all rsp_* stable while rsp_ready=0.
  - On rsp_valid&rsp_ready: clear rsp_valid and go to IDLE. rsp_f/flags keep their last values.
  - No new grant is issued in the RESP→IDLE cycle; at most one transaction is in flight.
- Latency: accept at cycle N; rsp_valid rises at N+2. Back-to-back throughput is one op per 3 cycles when rsp_ready is held high.
- Requesters must hold valid/op/a/b until ready. Dropping valid before ready is legal: nothing is granted.
- Fairness: under continuous dual requests, grants strictly alternate 0,1,0,1.
- Arithmetic (add/sub carry, OF, ZF) is owned entirely by the ALU; this block only passes values through, with no width change.
- rst asserted in any state, including EXEC or RESP with rsp_valid high:
  - Return to the reset values on the next edge.
  - The in-flight operation is discarded with no response.
  - last_grant returns to 1.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- When defined, add:
  - Ports: stat_clr (in, 1), grant_cnt0 (out, 16), grant_cnt1 (out, 16).
  - Each counter increments on its requester's accept and saturates at 16'hFFFF.
  - stat_clr=1 zeroes both counters synchronously, with priority over a same-cycle increment.
  - rst also zeroes both counters.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single op: req0 op=100, a=7, b=5, rsp_ready=1. Require req0_ready at cycle N, then rsp_valid at N+2 with rsp_id=0, rsp_f=12, zf=0, of=0.
- Overflow/zero:
  - req1 op=100, a=32'h7FFFFFFF, b=1 → rsp_f=32'h80000000, of=1, zf=0.
  - Then op=101, a=b=5 → rsp_f=0, zf=1, of=0.
- Contention: both valid continuously with 4 ops each. Grants must be 0,1,0,1,0,1,0,1, and each rsp_id must match its accept order.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP. rsp_f/flags must stay stable, req*_ready must stay 0, busy=1. Response completes on the cycle rsp_ready=1; the next accept occurs no earlier than the following cycle.
- Reset mid-op: assert rst in EXEC. Next cycle: state IDLE, rsp_valid=0, alu_* =0, and no response appears. The next dual request is granted to requester 0.
- ALU_ARB_STATS_EN: 3 grants to req0 and 2 to req1 → cnt0=3, cnt1=2. Then stat_clr together with a req0 accept in the same cycle → cnt0=0.

Source files
------------

// File: rtl/alu_share_arb.sv
// alu_share_arb: time-shares one combinational ALU between two requesters.
//
// Each transaction takes three states. In IDLE a round-robin grant accepts one request and
// registers its op/operands into the ALU inputs. In EXEC the ALU settles, and its result and
// flags are captured at the end of the cycle. In RESP the response is held until it is consumed.
// Only one transaction is in flight at a time.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   reqN_valid/ready/op/a/b   request channel for requester N (N = 0, 1)
//   alu_a, alu_b, alu_op      registered inputs to the shared ALU
//   alu_f, alu_zf, alu_of     ALU result and flags
//   rsp_valid/ready           response handshake
//   rsp_id, rsp_f, rsp_zf, rsp_of   captured response
//   busy                      high whenever the arbiter is not idle
//
// Optional feature (macro ALU_ARB_STATS_EN):
//   stat_clr                  synchronous clear of the grant counters
//   grant_cnt0, grant_cnt1    saturating per-requester accept counters

module alu_share_arb #(
    parameter int unsigned W   = 32,
    parameter int unsigned OPW = 3
) (
    input  logic           clk,
    input  logic           rst,
`ifdef ALU_ARB_STATS_EN
    input  logic           stat_clr,
    output logic [15:0]    grant_cnt0,
    output logic [15:0]    grant_cnt1,
`endif
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_op,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_op,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [W-1:0]   alu_f,
    input  logic           alu_zf,
    input  logic           alu_of,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [W-1:0]   rsp_f,
    output logic           rsp_zf,
    output logic           rsp_of,
    output logic           busy
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e         r_state;
    state_e         w_state_d;
    logic           r_last_grant;
    logic           r_cur_id;
    logic [W-1:0]   r_alu_a;
    logic [W-1:0]   r_alu_b;
    logic [OPW-1:0] r_alu_op;
    logic           r_rsp_valid;
    logic           r_rsp_id;
    logic [W-1:0]   r_rsp_f;
    logic           r_rsp_zf;
    logic           r_rsp_of;
    logic           w_gnt0;
    logic           w_gnt1;

    always_comb begin
        w_gnt0    = 1'b0;
        w_gnt1    = 1'b0;
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                // Requester 0 wins if alone, or if requester 1 had the previous grant.
                if (req0_valid && (!req1_valid || r_last_grant)) begin
                    w_gnt0 = 1'b1;
                end else if (req1_valid) begin
                    w_gnt1 = 1'b1;
                end
                if (w_gnt0 || w_gnt1) begin
                    w_state_d = StExec;
                end
            end
            StExec: w_state_d = StResp;
            StResp: begin
                if (rsp_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_last_grant <= 1'b1;
            r_cur_id     <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_f      <= '0;
            r_rsp_zf     <= 1'b0;
            r_rsp_of     <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_gnt0 || w_gnt1) begin
                r_alu_a      <= w_gnt1 ? req1_a  : req0_a;
                r_alu_b      <= w_gnt1 ? req1_b  : req0_b;
                r_alu_op     <= w_gnt1 ? req1_op : req0_op;
                r_cur_id     <= w_gnt1;
                r_last_grant <= w_gnt1;
            end
            if (r_state == StExec) begin
                r_rsp_f     <= alu_f;
                r_rsp_zf    <= alu_zf;
                r_rsp_of    <= alu_of;
                r_rsp_id    <= r_cur_id;
                r_rsp_valid <= 1'b1;
            end
            // Result and flags keep their last values after the handshake.
            if ((r_state == StResp) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;

    // Clear takes priority over a same-cycle accept; counters saturate at all-ones.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_gnt0 && (r_cnt0 != 16'hFFFF)) begin
                r_cnt0 <= r_cnt0 + 16'd1;
            end
            if (w_gnt1 && (r_cnt1 != 16'hFFFF)) begin
                r_cnt1 <= r_cnt1 + 16'd1;
            end
        end
    end

    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;
`endif

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_f      = r_rsp_f;
    assign rsp_zf     = r_rsp_zf;
    assign rsp_of     = r_rsp_of;
    assign busy       = (r_state != StIdle);

endmodule
